// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit order and hex-digit patterns shared with the display driver
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A_PAT = 7'h77;
  localparam seg_t SEG_B_PAT = 7'h7C;
  localparam seg_t SEG_C_PAT = 7'h39;
  localparam seg_t SEG_D_PAT = 7'h5E;
  localparam seg_t SEG_E_PAT = 7'h79;
  localparam seg_t SEG_F_PAT = 7'h71;
  localparam seg_t SEG_PAT [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A_PAT, SEG_B_PAT, SEG_C_PAT, SEG_D_PAT, SEG_E_PAT, SEG_F_PAT
  };
endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: pad-side segment bus and the capture results
interface seg7_capture_if #(parameter int PERIOD_W = 24);
  logic [6:0]          seg_in;
  logic [3:0]          digit;
  logic                digit_valid;
  logic                invalid;
  logic [7:0]          seq_err_count;
  logic [PERIOD_W-1:0] period;
  modport master (output seg_in, input digit, digit_valid, invalid, seq_err_count, period);
  modport slave  (input seg_in, output digit, digit_valid, invalid, seq_err_count, period);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: maps a segment pattern back to its hex digit
module seg7_decode
  import seg7_pkg::*;
(
  input  seg_t       pat,
  output logic [3:0] digit,
  output logic       hit,
  output logic       blank
);
  always_comb begin
    digit = '0;
    hit = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pat == SEG_PAT[i]) begin
        digit = 4'(i);
        hit = 1'b1;
      end
    blank = pat == SEG_BLANK;
  end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: debounces the pad segment bus, decodes digits, checks count order and period
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W = 24
) (
  input logic clk,
  input logic rst_n,
  seg7_capture_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  seg_t s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, last_pat_q, last_pat_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0] digit_q, digit_d, dec_digit;
  logic digit_valid_q, digit_valid_d, invalid_q, invalid_d;
  logic has_prev_q, has_prev_d;
  logic [7:0] err_q, err_d;
  logic [PERIOD_W-1:0] gap_q, gap_d, period_q, period_d, gap_inc;
  logic chg, accept, hit, blank, valid;
  seg7_decode u_dec (.pat(cand_q), .digit(dec_digit), .hit(hit), .blank(blank));
  always_comb begin
    s1_d = bus.seg_in;
    s2_d = s1_q;
    chg = s2_q != cand_q;
    cand_d = s2_q;
    stab_d = chg ? '0 : (stab_q == STAB_MAX ? stab_q : stab_q + 1'b1);
    accept = !chg && stab_q == STAB_MAX && cand_q != last_pat_q;
    last_pat_d = accept ? cand_q : last_pat_q;
    valid = accept && hit;
    digit_d = valid ? dec_digit : digit_q;
    digit_valid_d = valid;
    invalid_d = accept && !hit && !blank;
    has_prev_d = has_prev_q | valid;
    err_d = (valid && has_prev_q && dec_digit != digit_q + 4'd1 && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    gap_inc = &gap_q ? gap_q : gap_q + 1'b1;
    gap_d = valid ? '0 : gap_inc;
    period_d = (valid && has_prev_q) ? gap_inc : period_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= SEG_BLANK;
      s2_q <= SEG_BLANK;
      cand_q <= SEG_BLANK;
      last_pat_q <= SEG_BLANK;
      stab_q <= '0;
      digit_q <= '0;
      digit_valid_q <= 1'b0;
      invalid_q <= 1'b0;
      has_prev_q <= 1'b0;
      err_q <= '0;
      gap_q <= '0;
      period_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      cand_q <= cand_d;
      last_pat_q <= last_pat_d;
      stab_q <= stab_d;
      digit_q <= digit_d;
      digit_valid_q <= digit_valid_d;
      invalid_q <= invalid_d;
      has_prev_q <= has_prev_d;
      err_q <= err_d;
      gap_q <= gap_d;
      period_q <= period_d;
    end
  end
  assign bus.digit = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.invalid = invalid_q;
  assign bus.seq_err_count = err_q;
  assign bus.period = period_q;
endmodule
